// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the SRAM burst controller.
package sram_ctrl_pkg;

    localparam int ADDR_WD = 8;
    localparam int DATA_WD = 8;
    localparam int LEN_WD  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/sram_burst_ctrl.sv
// Initiator-side burst controller for the 8x256 synchronous SRAM: turns
// valid/ready burst requests into registered SRAM strobes and returns read beats.
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WD = sram_ctrl_pkg::ADDR_WD,
    parameter int DATA_WD = sram_ctrl_pkg::DATA_WD,
    parameter int LEN_WD  = sram_ctrl_pkg::LEN_WD
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               reqValid,
    output logic               reqReady,
    input  logic               reqWrite,
    input  logic [ADDR_WD-1:0] reqAddr,
    input  logic [LEN_WD-1:0]  reqLen,
    input  logic               wrValid,
    output logic               wrReady,
    input  logic [DATA_WD-1:0] wrData,
    output logic               rspValid,
    output logic [DATA_WD-1:0] rspData,
    output logic [ADDR_WD-1:0] addrLine,
    output logic [DATA_WD-1:0] inDataLine,
    output logic               chipSel,
    output logic               readData,
    output logic               writeData,
    input  logic [DATA_WD-1:0] outDataLine,
    output ctrl_state_t        dbgState
);

    // Handshakes: a request transfers on a rising edge where reqValid && reqReady;
    // a write beat transfers on a rising edge where wrValid && wrReady. Neither
    // ready depends on its valid. Read responses have no backpressure.

    ctrl_state_t        state, state_nx;
    logic [LEN_WD-1:0]  cnt, cnt_nx;
    logic [ADDR_WD-1:0] cur_addr, cur_addr_nx, addr_nx;
    logic [DATA_WD-1:0] wdata_nx;
    logic               rd_nx, wr_nx;
    logic               rd_pend;

    assign reqReady = (state == IDLE);
    assign wrReady  = (state == WRITE);
    assign rspValid = rd_pend;
    assign rspData  = outDataLine;
    assign dbgState = state;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cur_addr_nx = cur_addr;
        addr_nx     = addrLine;
        wdata_nx    = inDataLine;
        rd_nx       = 1'b0;
        wr_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    cur_addr_nx = reqAddr;
                    cnt_nx      = reqLen;
                    if (reqWrite) begin
                        state_nx = WRITE;
                    end else begin
                        // First read beat goes out on the accepting edge.
                        addr_nx  = reqAddr;
                        rd_nx    = 1'b1;
                        state_nx = (reqLen == '0) ? IDLE : READ;
                    end
                end
            end
            READ: begin
                addr_nx     = cur_addr + ADDR_WD'(1);
                cur_addr_nx = cur_addr + ADDR_WD'(1);
                rd_nx       = 1'b1;
                cnt_nx      = cnt - LEN_WD'(1);
                if (cnt == LEN_WD'(1)) state_nx = IDLE;
            end
            WRITE: begin
                if (wrValid) begin
                    addr_nx     = cur_addr;
                    wdata_nx    = wrData;
                    wr_nx       = 1'b1;
                    cur_addr_nx = cur_addr + ADDR_WD'(1);
                    cnt_nx      = cnt - LEN_WD'(1);
                    if (cnt == '0) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_addr   <= '0;
            addrLine   <= '0;
            inDataLine <= '0;
            chipSel    <= 1'b0;
            readData   <= 1'b0;
            writeData  <= 1'b0;
            rd_pend    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cur_addr   <= cur_addr_nx;
            addrLine   <= addr_nx;
            inDataLine <= wdata_nx;
            chipSel    <= rd_nx | wr_nx;
            readData   <= rd_nx;
            writeData  <= wr_nx;
            // SRAM samples the strobe one edge later; its data is valid after that.
            rd_pend    <= readData;
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a behavioural 8x256 synchronous SRAM.
module tb_sram_burst_ctrl;
    import sram_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        reqValid, reqWrite, wrValid;
    logic [7:0]  reqAddr, wrData;
    logic [3:0]  reqLen;
    logic        reqReady, wrReady, rspValid;
    logic [7:0]  rspData, addrLine, inDataLine, outDataLine;
    logic        chipSel, readData, writeData;
    ctrl_state_t dbgState;

    int n_cmp = 0;
    int n_err = 0;

    sram_burst_ctrl dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqLen(reqLen),
        .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData),
        .rspValid(rspValid), .rspData(rspData),
        .addrLine(addrLine), .inDataLine(inDataLine), .chipSel(chipSel),
        .readData(readData), .writeData(writeData), .outDataLine(outDataLine),
        .dbgState(dbgState)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        outDataLine = 8'h00;
    end
    always @(posedge clock) begin
        if (chipSel && writeData) mem[addrLine] <= inDataLine;
        if (chipSel && readData) outDataLine <= mem[addrLine];
    end

    // monitor: samples on the falling edge
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], rsp_q[$];
    int rd_cyc_q[$], rsp_cyc_q[$];
    int acc_count = 0, last_acc = 0, both_err = 0, stall_count = 0;

    always @(negedge clock) begin
        if (reqValid && reqReady) begin
            acc_count++;
            last_acc = cyc;
        end
        if (reqValid && !reqReady) stall_count++;
        if (writeData) begin
            wr_addr_q.push_back(addrLine);
            wr_data_q.push_back(inDataLine);
        end
        if (readData) begin
            rd_addr_q.push_back(addrLine);
            rd_cyc_q.push_back(cyc);
        end
        if (rspValid) begin
            rsp_q.push_back(rspData);
            rsp_cyc_q.push_back(cyc);
        end
        if (readData && writeData) both_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rsp_q.delete();
        rd_cyc_q.delete(); rsp_cyc_q.delete();
        acc_count = 0; stall_count = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // driver: holds the request until it is accepted, returns 1 ns after that edge
    task automatic send_req(input logic w, input logic [7:0] a, input logic [3:0] l);
        int n;
        n = 0;
        reqValid = 1'b1; reqWrite = w; reqAddr = a; reqLen = l;
        @(negedge clock);
        while (!reqReady && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("req_accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clock);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic wr_beat(input logic [7:0] d);
        wrValid = 1'b1; wrData = d;
        @(negedge clock);
        chk("wr_ready_beat", 32'(wrReady), 32'd1);
        @(posedge clock);
        #1;
        wrValid = 1'b0;
    endtask

    initial begin
        reqValid = 0; reqWrite = 0; reqAddr = 0; reqLen = 0;
        wrValid = 0; wrData = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_req_ready", 32'(reqReady), 32'd1);
        chk("rst_wr_ready", 32'(wrReady), 32'd0);
        chk("rst_chip_sel", 32'(chipSel), 32'd0);
        chk("rst_rsp_valid", 32'(rspValid), 32'd0);
        chk("rst_addr_line", 32'(addrLine), 32'd0);
        chk("rst_state", 32'(dbgState), 32'(IDLE));
        idle(2);
        reset = 1'b0;
        idle(1);

        // single write then single read
        clear_mon();
        send_req(1'b1, 8'h10, 4'd0);
        wr_beat(8'hA5);
        idle(2);
        chk("t1_wr_count", wr_addr_q.size(), 1);
        chk("t1_wr_addr", 32'(wr_addr_q[0]), 32'h10);
        chk("t1_wr_data", 32'(wr_data_q[0]), 32'hA5);
        clear_mon();
        send_req(1'b0, 8'h10, 4'd0);
        idle(4);
        chk("t1_rd_count", rd_addr_q.size(), 1);
        chk("t1_rsp_count", rsp_q.size(), 1);
        chk("t1_rsp_data", 32'(rsp_q[0]), 32'hA5);
        chk("t1_rsp_latency", rsp_cyc_q[0] - last_acc, 2);

        // write burst with a two-cycle gap before beat 3
        clear_mon();
        send_req(1'b1, 8'h20, 4'd3);
        wr_beat(8'h01);
        wr_beat(8'h02);
        idle(2);
        chk("t2_gap_wr_ready", 32'(wrReady), 32'd1);
        chk("t2_gap_no_strobe", wr_addr_q.size(), 2);
        wr_beat(8'h03);
        wr_beat(8'h04);
        idle(1);
        chk("t2_wr_count", wr_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_wr_addr", 32'(wr_addr_q[i]), 32'h20 + 32'(i));
            chk("t2_wr_data", 32'(wr_data_q[i]), 32'(i + 1));
        end
        chk("t2_idle_after", 32'(reqReady), 32'd1);
        clear_mon();
        send_req(1'b0, 8'h20, 4'd3);
        idle(6);
        chk("t2_rsp_count", rsp_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_rsp_data", 32'(rsp_q[i]), 32'(i + 1));
        chk("t2_rsp_consecutive", rsp_cyc_q[3] - rsp_cyc_q[0], 3);
        chk("t2_rsp_latency", rsp_cyc_q[0] - last_acc, 2);

        // wrap-around burst
        clear_mon();
        send_req(1'b1, 8'hFE, 4'd3);
        wr_beat(8'h11);
        wr_beat(8'h22);
        wr_beat(8'h33);
        wr_beat(8'h44);
        idle(1);
        chk("t3_wr_count", wr_addr_q.size(), 4);
        chk("t3_wr_addr0", 32'(wr_addr_q[0]), 32'hFE);
        chk("t3_wr_addr1", 32'(wr_addr_q[1]), 32'hFF);
        chk("t3_wr_addr2", 32'(wr_addr_q[2]), 32'h00);
        chk("t3_wr_addr3", 32'(wr_addr_q[3]), 32'h01);
        clear_mon();
        send_req(1'b0, 8'hFE, 4'd3);
        idle(6);
        chk("t3_rd_addr2", 32'(rd_addr_q[2]), 32'h00);
        chk("t3_rsp_count", rsp_q.size(), 4);
        chk("t3_rsp0", 32'(rsp_q[0]), 32'h11);
        chk("t3_rsp1", 32'(rsp_q[1]), 32'h22);
        chk("t3_rsp2", 32'(rsp_q[2]), 32'h33);
        chk("t3_rsp3", 32'(rsp_q[3]), 32'h44);

        // back-to-back: read len 1 then write
        clear_mon();
        both_err = 0;
        send_req(1'b0, 8'h20, 4'd1);
        send_req(1'b1, 8'h30, 4'd0);
        wr_beat(8'h5A);
        idle(3);
        chk("t4_rd_count", rd_addr_q.size(), 2);
        chk("t4_wr_accept_cycle", last_acc, rd_cyc_q[1]);
        chk("t4_acc_count", acc_count, 2);
        chk("t4_rsp_count", rsp_q.size(), 2);
        chk("t4_rsp0", 32'(rsp_q[0]), 32'h01);
        chk("t4_rsp1", 32'(rsp_q[1]), 32'h02);
        chk("t4_wr_addr", 32'(wr_addr_q[0]), 32'h30);
        chk("t4_wr_data", 32'(wr_data_q[0]), 32'h5A);
        chk("t4_strobes_exclusive", both_err, 0);

        // handshake hold across a burst
        clear_mon();
        send_req(1'b0, 8'h20, 4'd3);
        send_req(1'b0, 8'hFE, 4'd0);
        idle(4);
        chk("t6_stall_cycles", stall_count, 3);
        chk("t6_acc_count", acc_count, 2);
        chk("t6_rd_count", rd_addr_q.size(), 5);
        chk("t6_rsp_count", rsp_q.size(), 5);
        chk("t6_rsp3", 32'(rsp_q[3]), 32'h04);
        chk("t6_rsp4", 32'(rsp_q[4]), 32'h11);

        // reset in the middle of a len-7 read
        clear_mon();
        send_req(1'b0, 8'h00, 4'd7);
        idle(2);
        chk("t5_pre_read_strobe", 32'(readData), 32'd1);
        chk("t5_pre_rsp_valid", 32'(rspValid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_chip_sel", 32'(chipSel), 32'd0);
        chk("t5_read_strobe", 32'(readData), 32'd0);
        chk("t5_rsp_valid", 32'(rspValid), 32'd0);
        clear_mon();
        idle(2);
        reset = 1'b0;
        chk("t5_no_strobe_in_reset", rd_addr_q.size(), 0);
        chk("t5_req_ready", 32'(reqReady), 32'd1);
        chk("t5_wr_ready", 32'(wrReady), 32'd0);
        idle(1);
        clear_mon();
        send_req(1'b0, 8'h21, 4'd0);
        idle(4);
        chk("t5_fresh_rsp_count", rsp_q.size(), 1);
        chk("t5_fresh_rsp_data", 32'(rsp_q[0]), 32'h02);
        chk("t5_fresh_rd_count", rd_addr_q.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
